// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg
// Shared definitions for the RV32I decode stage.
//   - opcode constants for the instruction groups this stage decodes
//   - ALU class codes carried in the low bits of alu_op
//   - bit positions of the fields inside alu_op
//   - alu_op_pack(): builds an alu_op word from {alt, funct3, class}
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_CLS_R     = 3'b000,
        ALU_CLS_I     = 3'b001,
        ALU_CLS_LUI   = 3'b010,
        ALU_CLS_AUIPC = 3'b011
    } alu_cls_e;

    // alu_op = {alt, funct3[2:0], class[2:0]}
    localparam int ALU_OP_ALT_BIT = 6;
    localparam int ALU_OP_F3_LSB  = 3;
    localparam int ALU_OP_CLS_LSB = 0;

    function automatic logic [6:0] alu_op_pack(input logic       alt,
                                               input logic [2:0] funct3,
                                               input alu_cls_e   cls);
        logic [6:0] op;
        op                          = '0;
        op[ALU_OP_ALT_BIT]          = alt;
        op[ALU_OP_F3_LSB +: 3]      = funct3;
        op[ALU_OP_CLS_LSB +: 3]     = cls;
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// ============================================================================
// regfile
// Integer register file: 2 asynchronous read ports, 1 synchronous write port,
// synchronous active-high reset clearing every register.
//   clk, rst          clock / synchronous reset (writes ignored under reset)
//   raddr[2], rdata[2] read ports (x0 always reads 0)
//   we, waddr, wdata   write port (writes to x0 are dropped)
// Optional macro DECODE_WB_BYPASS_EN: a read of the register being written in
// the same cycle returns the write data instead of the stored value.
// ============================================================================
module regfile
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0][AW-1:0]   raddr,
    output logic [1:0][XLEN-1:0] rdata,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [XLEN-1:0]      wdata
);

    logic [XLEN-1:0] regs_q [NREG];

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
`ifdef DECODE_WB_BYPASS_EN
            assign rdata[gi] = (raddr[gi] == '0)                ? '0    :
                               (we && (waddr == raddr[gi]))     ? wdata :
                                                                  regs_q[raddr[gi]];
`else
            assign rdata[gi] = (raddr[gi] == '0) ? '0 : regs_q[raddr[gi]];
`endif
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage
// RV32I decode stage: decodes OP / OP-IMM / LUI / AUIPC, reads the register
// file and presents {operand1, operand2, alu_op, rd_addr, rd_we, illegal}
// to execute through a registered valid/ready output.
//   clk, rst                      clock / synchronous active-high reset
//   if_valid, if_ready, if_instr, if_pc   fetch-side handshake and payload
//   ex_valid, ex_ready            execute-side handshake
//   operand1, operand2, alu_op, rd_addr, rd_we, illegal   output bundle
//   wb_we, wb_addr, wb_data       writeback port into the register file
// Optional macro DECODE_WB_BYPASS_EN: write-through bypass in the regfile.
// ============================================================================
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int NREG     = 32,
    parameter int ALU_OP_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [31:0]         if_instr,
    input  logic [XLEN-1:0]     if_pc,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [XLEN-1:0]     operand1,
    output logic [XLEN-1:0]     operand2,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [4:0]          rd_addr,
    output logic                rd_we,
    output logic                illegal,
    input  logic                wb_we,
    input  logic [4:0]          wb_addr,
    input  logic [XLEN-1:0]     wb_data
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];

    logic [1:0][4:0]      rf_raddr;
    logic [1:0][XLEN-1:0] rf_rdata;
    assign rf_raddr[0] = if_instr[19:15];
    assign rf_raddr[1] = if_instr[24:20];

    regfile #(.XLEN(XLEN), .NREG(NREG), .AW(5)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .raddr (rf_raddr),
        .rdata (rf_rdata),
        .we    (wb_we && !rst),
        .waddr (wb_addr),
        .wdata (wb_data)
    );

    logic [XLEN-1:0]     op1_d, op2_d;
    logic [ALU_OP_W-1:0] alu_op_d;
    logic                legal_d;

    always_comb begin
        op1_d    = '0;
        op2_d    = '0;
        alu_op_d = '0;
        legal_d  = 1'b0;
        case (opcode)
            OPC_OP: begin
                // Only SUB/SRA may set funct7[5]; every other funct7 is reserved.
                legal_d  = (funct7 == 7'b0000000) ||
                           ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                op1_d    = rf_rdata[0];
                op2_d    = rf_rdata[1];
                alu_op_d = ALU_OP_W'(alu_op_pack(if_instr[30], funct3, ALU_CLS_R));
            end
            OPC_OP_IMM: begin
                op1_d = rf_rdata[0];
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    // Shift-immediate: shamt is unsigned; only bit 30 may be set
                    // in the upper field, and it only selects SRAI.
                    legal_d  = ({funct7[6], funct7[4:0]} == 6'b0);
                    op2_d    = XLEN'(if_instr[24:20]);
                    alu_op_d = ALU_OP_W'(alu_op_pack((funct3 == 3'b101) && if_instr[30],
                                                     funct3, ALU_CLS_I));
                end else begin
                    legal_d  = 1'b1;
                    op2_d    = XLEN'($signed(if_instr[31:20]));
                    alu_op_d = ALU_OP_W'(alu_op_pack(1'b0, funct3, ALU_CLS_I));
                end
            end
            OPC_LUI: begin
                legal_d  = 1'b1;
                op2_d    = XLEN'({if_instr[31:12], 12'b0});
                alu_op_d = ALU_OP_W'(alu_op_pack(1'b0, 3'b000, ALU_CLS_LUI));
            end
            OPC_AUIPC: begin
                legal_d  = 1'b1;
                op1_d    = if_pc;
                op2_d    = XLEN'({if_instr[31:12], 12'b0});
                alu_op_d = ALU_OP_W'(alu_op_pack(1'b0, 3'b000, ALU_CLS_AUIPC));
            end
            default: legal_d = 1'b0;
        endcase
        // An illegal encoding still travels down the pipe, but as an inert bundle.
        if (!legal_d) begin
            op1_d    = '0;
            op2_d    = '0;
            alu_op_d = '0;
        end
    end

    logic                ex_valid_q;
    logic [XLEN-1:0]     op1_q, op2_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic [4:0]          rd_addr_q;
    logic                rd_we_q, illegal_q;

    assign if_ready = !ex_valid_q || ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            alu_op_q   <= '0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (if_valid && if_ready) begin
            ex_valid_q <= 1'b1;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            alu_op_q   <= alu_op_d;
            rd_addr_q  <= if_instr[11:7];
            rd_we_q    <= legal_d && (if_instr[11:7] != 5'd0);
            illegal_q  <= !legal_d;
        end else if (ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid = ex_valid_q;
    assign operand1 = op1_q;
    assign operand2 = op2_q;
    assign alu_op   = alu_op_q;
    assign rd_addr  = rd_addr_q;
    assign rd_we    = rd_we_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        ex_valid, ex_ready;
    logic [31:0] operand1, operand2;
    logic [6:0]  alu_op;
    logic [4:0]  rd_addr;
    logic        rd_we, illegal;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .operand1 (operand1),
        .operand2 (operand2),
        .alu_op   (alu_op),
        .rd_addr  (rd_addr),
        .rd_we    (rd_we),
        .illegal  (illegal),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [6:0]  alu;
        logic [4:0]  rd;
        logic        rd_we;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_rf [32];
    bit          exp_valid = 1'b0;
    bit          out_zero  = 1'b0;
    bit          mon_en    = 1'b0;
    int          checks    = 0;
    int          passes    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference decode, straight from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   f3, cls, alt, imm;
        bit   ok;
        logic [6:0] f7;
        f3 = int'(ins[14:12]);
        f7 = ins[31:25];
        cls = 0; alt = 0; ok = 1'b0;
        e.op1 = 32'd0;
        e.op2 = 32'd0;
        case (ins[6:0])
            7'h33: begin
                ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.op1 = a; e.op2 = b; alt = int'(ins[30]); cls = 0;
            end
            7'h13: begin
                cls = 1; e.op1 = a;
                if (f3 == 1 || f3 == 5) begin
                    ok    = ((f7 & 7'h5F) == 7'h00);
                    e.op2 = 32'(ins[24:20]);
                    alt   = (f3 == 5) ? int'(ins[30]) : 0;
                end else begin
                    ok  = 1'b1;
                    imm = int'(ins[31:20]);
                    if (imm >= 2048) imm = imm - 4096;
                    e.op2 = imm;
                end
            end
            7'h37: begin ok = 1'b1; cls = 2; f3 = 0; e.op2 = (ins >> 12) << 12; end
            7'h17: begin ok = 1'b1; cls = 3; f3 = 0; e.op1 = pc; e.op2 = (ins >> 12) << 12; end
            default: ok = 1'b0;
        endcase
        e.alu = ok ? 7'(alt * 64 + f3 * 8 + cls) : 7'd0;
        if (!ok) begin e.op1 = 32'd0; e.op2 = 32'd0; end
        e.ill   = !ok;
        e.rd    = ins[11:7];
        e.rd_we = ok && (ins[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_we && wb_addr == r) return wb_data;
`endif
        return model_rf[r];
    endfunction

    // Model: advances on every clock edge using the inputs driven for that cycle.
    always @(posedge clk) begin
        bit rdy;
        rdy = !exp_valid || ex_ready;
        if (rst) begin
            sb_q.delete();
            exp_valid = 1'b0;
            out_zero  = 1'b1;
            for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        end else begin
            if (if_valid && rdy) begin
                sb_q.push_back(ref_decode(if_instr, if_pc,
                                          model_read(if_instr[19:15]),
                                          model_read(if_instr[24:20])));
                exp_valid = 1'b1;
                out_zero  = 1'b0;
            end else if (ex_ready) begin
                exp_valid = 1'b0;
            end
            if (wb_we && wb_addr != 5'd0) model_rf[wb_addr] = wb_data;
        end
    end

    // Monitor: compares what the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("if_ready", 32'(if_ready), 32'(!exp_valid || ex_ready));
            chk("ex_valid", 32'(ex_valid), 32'(exp_valid));
            if (out_zero) begin
                chk("rst_operand1", operand1, 32'd0);
                chk("rst_operand2", operand2, 32'd0);
                chk("rst_alu_op",   32'(alu_op), 32'd0);
                chk("rst_rd",       32'({rd_addr, rd_we, illegal}), 32'd0);
            end
            if (exp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard: expected bundle missing, ex_valid=%0b", ex_valid);
                end else begin
                    e = sb_q[0];
                    chk("operand1", operand1, e.op1);
                    chk("operand2", operand2, e.op2);
                    chk("alu_op",   32'(alu_op), 32'(e.alu));
                    chk("rd_addr",  32'(rd_addr), 32'(e.rd));
                    chk("rd_we",    32'(rd_we), 32'(e.rd_we));
                    chk("illegal",  32'(illegal), 32'(e.ill));
                    $display("txn instr-bundle op1=%h op2=%h alu_op=%b rd=%0d we=%0b ill=%0b",
                             operand1, operand2, alu_op, rd_addr, rd_we, illegal);
                    if (ex_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        if_valid = 1'b1; if_instr = ins; if_pc = pc;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = !exp_valid || ex_ready;
            @(posedge clk); #1;
            wb_we = 1'b0;
            n++;
        end
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: instr %h not accepted in %0d cycles", ins, n);
        end
        if_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d; if_valid = 1'b0;
        @(posedge clk); #1;
        wb_we = 1'b0;
    endtask

    task automatic expect_bundle(input string name, input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [6:0] alu, input logic we, input logic ill);
        @(negedge clk);
        chk({name, "_valid"}, 32'(ex_valid), 32'd1);
        chk({name, "_op1"},   operand1, op1);
        chk({name, "_op2"},   operand2, op2);
        chk({name, "_alu"},   32'(alu_op), 32'(alu));
        chk({name, "_rdwe"},  32'(rd_we), 32'(we));
        chk({name, "_ill"},   32'(illegal), 32'(ill));
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rs1, rs2, rd;
        logic [6:0] opc;
        int sel;
        sel = int'($urandom_range(0, 5));
        f7  = 7'($urandom);
        f3  = 3'($urandom);
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        case (sel)
            0: begin opc = 7'h33; if ($urandom_range(0, 3) != 0) f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            1: opc = 7'h13;
            2: begin opc = 7'h13; f3 = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
                     if ($urandom_range(0, 3) != 0) f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            3: opc = 7'h37;
            4: opc = 7'h17;
            default: opc = 7'($urandom);
        endcase
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        ex_ready = 1'b1; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // ADDI x1,x0,5
        send(32'h00500093, 32'h0);
        expect_bundle("addi", 32'd0, 32'd5, 7'b0000001, 1'b1, 1'b0);
        chk("addi_rd", 32'(rd_addr), 32'd1);

        // SUB x3,x1,x2 with x1=10, x2=3
        wb_write(5'd1, 32'd10);
        wb_write(5'd2, 32'd3);
        send(32'h402081B3, 32'h0);
        expect_bundle("sub", 32'd10, 32'd3, 7'b1000000, 1'b1, 1'b0);

        send(32'h123452B7, 32'h0);
        expect_bundle("lui", 32'd0, 32'h12345000, 7'b0000010, 1'b1, 1'b0);
        send(32'h4030D213, 32'h0);
        expect_bundle("srai", 32'd10, 32'd3, 7'b1101001, 1'b1, 1'b0);

        // Backpressure: bundle held for 3 cycles while fetch keeps offering.
        send(32'h00100313, 32'h0);
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h00200393;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_if_ready", 32'(if_ready), 32'd0);
            chk("bp_hold_op2", operand2, 32'd1);
        end
        @(posedge clk); #1;
        ex_ready = 1'b1;
        @(posedge clk); #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_op2", operand2, 32'd2);

        // Writeback in the same cycle as the read of x1.
        wb_write(5'd1, 32'd7);
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000DEAD;
        send(32'h00008133, 32'h0);
`ifdef DECODE_WB_BYPASS_EN
        expect_bundle("wb_same_cycle", 32'h0000DEAD, 32'd0, 7'b0000000, 1'b1, 1'b0);
`else
        expect_bundle("wb_same_cycle", 32'd7, 32'd0, 7'b0000000, 1'b1, 1'b0);
`endif
        send(32'h00008133, 32'h0);
        expect_bundle("wb_visible", 32'h0000DEAD, 32'd0, 7'b0000000, 1'b1, 1'b0);

        wb_write(5'd0, 32'h55);
        send(32'h00000133, 32'h0);
        expect_bundle("x0_read", 32'd0, 32'd0, 7'b0000000, 1'b1, 1'b0);

        // Unsupported opcode (load)
        send(32'h00002083, 32'h0);
        expect_bundle("load_illegal", 32'd0, 32'd0, 7'b0000000, 1'b0, 1'b1);

        // AUIPC passes the PC
        send(32'h00001197, 32'h00000400);
        expect_bundle("auipc", 32'h00000400, 32'h00001000, 7'b0000011, 1'b1, 1'b0);

        // Reset while a bundle is held
        ex_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        chk("rst_held_valid", 32'(ex_valid), 32'd0);
        chk("rst_held_op1",   operand1, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rst      = ($urandom_range(0, 99) == 0);
            if_valid = ($urandom_range(0, 2) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            if_instr = gen_instr();
            if_pc    = $urandom;
            wb_we    = ($urandom_range(0, 1) != 0);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b0; if_valid = 1'b0; ex_ready = 1'b1; wb_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
